// File: rtl/led_scan_ctrl.sv
// Multiplexed 5x7 LED matrix scanner with an Avalon-MM register front end.
// Frames are double buffered: software writes the back buffer, the scan reads a shadow copy.
module led_scan_ctrl #(
  parameter logic [15:0] DWELL_RST = 16'd49999,
  parameter int          BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [4:0]  col_out,
  output logic [6:0]  row_out,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [3:0]  blank_cnt;
  logic [15:0] dwell_cnt;
  logic [15:0] dwell;
  logic        en;
  logic        pol;
  logic        frame_tick_q;
  logic [6:0]  back_buf   [5];
  logic [6:0]  shadow_buf [5];
  logic [4:0]  col_active;
  logic        unused_wdata;

  // Handshake: a write is accepted in any cycle with chipselect=1 and write_n=0,
  // with no wait states; reads are purely combinational on address.
  wire wr_en = chipselect & ~write_n;

  assign unused_wdata = ^writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) back_buf[i] <= '0;
      en    <= 1'b0;
      pol   <= 1'b0;
      dwell <= DWELL_RST;
    end else if (wr_en) begin
      for (int i = 0; i < 5; i++)
        if (address == 3'(i)) back_buf[i] <= writedata[6:0];
      if (address == 3'd5) begin
        en  <= writedata[0];
        pol <= writedata[1];
      end
      if (address == 3'd6) dwell <= writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      blank_cnt    <= '0;
      dwell_cnt    <= '0;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < 5; i++) shadow_buf[i] <= '0;
    end else begin
      frame_tick_q <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        idx       <= '0;
        blank_cnt <= '0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= BLANK;
            idx        <= '0;
            blank_cnt  <= '0;
            shadow_buf <= back_buf;
          end
          BLANK: begin
            if (blank_cnt == BLANK_LAST) begin
              state     <= SHOW;
              blank_cnt <= '0;
              dwell_cnt <= '0;
            end else begin
              blank_cnt <= blank_cnt + 4'd1;
            end
          end
          SHOW: begin
            // dwell is compared live, so a new value applies at the next comparison
            if (dwell_cnt == dwell) begin
              state     <= BLANK;
              dwell_cnt <= '0;
              if (idx == 3'd4) begin
                idx          <= '0;
                frame_tick_q <= 1'b1;
                shadow_buf   <= back_buf;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    col_active = '0;
    row_out    = '0;
    if (state == SHOW) begin
      for (int i = 0; i < 5; i++) begin
        if (idx == 3'(i)) begin
          col_active[i] = 1'b1;
          row_out       = shadow_buf[i];
        end
      end
    end
  end

  assign col_out    = col_active ^ {5{pol}};
  assign frame_tick = frame_tick_q;

  always_comb begin
    readdata = '0;
    for (int i = 0; i < 5; i++)
      if (address == 3'(i)) readdata = {25'd0, back_buf[i]};
    case (address)
      3'd5:    readdata = {30'd0, pol, en};
      3'd6:    readdata = {16'd0, dwell};
      3'd7:    readdata = {28'd0, (state != IDLE), idx};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized bench for led_scan_ctrl: a frame-position model predicts every cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_led_scan_ctrl;

  localparam int          BLANK_CYC = 2;
  localparam logic [15:0] DWELL_RST = 16'd49999;
  localparam int          W = 17;  // {status[3:0], tick, row[6:0], col[4:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd7;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [4:0]  col_out;
  logic [6:0]  row_out;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // reference model: position within the frame, counted from frame start
  bit         m_en, m_pol, m_active, m_tick;
  int         m_dwell, m_t;
  logic [6:0] m_back [5];
  logic [6:0] m_shadow [5];

  always #5 clk = ~clk;

  led_scan_ctrl #(.DWELL_RST(DWELL_RST), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .col_out(col_out), .row_out(row_out), .frame_tick(frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_pol = 0; m_active = 0; m_tick = 0; m_t = 0;
    m_dwell = int'(DWELL_RST);
    for (int i = 0; i < 5; i++) begin
      m_back[i] = '0;
      m_shadow[i] = '0;
    end
  endfunction

  function automatic int col_period();
    return BLANK_CYC + m_dwell + 1;
  endfunction

  function automatic logic [W-1:0] model_out();
    int per, col;
    logic [4:0] c;
    logic [6:0] r;
    logic [3:0] st;
    per = col_period();
    c = '0; r = '0; st = '0;
    if (m_active) begin
      col = m_t / per;
      st = {1'b1, 3'(col)};
      if ((m_t % per) >= BLANK_CYC) begin
        c = 5'(1 << col);
        r = m_shadow[col];
      end
    end
    c = c ^ {5{m_pol}};
    return {st, m_tick, r, c};
  endfunction

  function automatic bit model_showing(input int col);
    int per;
    per = col_period();
    return m_active && (m_t / per == col) && (m_t % per >= BLANK_CYC);
  endfunction

  // one clock cycle, optionally carrying a write; called at posedge+1
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d);
    chipselect = wr;
    write_n = !wr;
    address = wr ? a : 3'd7;
    writedata = d;
    @(posedge clk);
    #1;
    if (!m_en) begin
      m_active = 0; m_t = 0; m_tick = 0;
    end else if (!m_active) begin
      m_active = 1; m_t = 0; m_tick = 0;
      m_shadow = m_back;
    end else begin
      m_t++;
      m_tick = 0;
      if (m_t == 5 * col_period()) begin
        m_t = 0; m_tick = 1;
        m_shadow = m_back;
      end
    end
    if (wr) begin
      if (a < 3'd5) m_back[a] = d[6:0];
      else if (a == 3'd5) begin m_en = d[0]; m_pol = d[1]; end
      else if (a == 3'd6) m_dwell = int'(d[15:0]);
    end
    exp_q.push_back(model_out());
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 3'd7;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1, a, d);
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
    address = 3'd7;
  endtask

  task automatic run_until_show(input int col, input int budget);
    int n = 0;
    while (!model_showing(col) && n < budget) begin
      step(0, 3'd0, 32'd0);
      n++;
    end
    check("wait_show_col", 32'(model_showing(col)), 32'd1);
  endtask

  // asynchronous reset asserted in the middle of a clock cycle
  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_col", 32'(col_out), 32'd0);
    check("rst_row", 32'(row_out), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rd_check("rst_dwell", 3'd6, 32'(DWELL_RST));
    rd_check("rst_status", 3'd7, 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("col_out", 32'(col_out), 32'(e[4:0]));
      check("row_out", 32'(row_out), 32'(e[11:5]));
      check("frame_tick", 32'(frame_tick), 32'(e[12]));
      if (address == 3'd7) check("status", readdata, {28'd0, e[16:13]});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] a;
    logic [31:0] d;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_col", 32'(col_out), 32'd0);
    check("rst_row", 32'(row_out), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rd_check("rst_dwell", 3'd6, 32'(DWELL_RST));
    rd_check("rst_ctrl", 3'd5, 32'd0);
    rd_check("rst_col0", 3'd0, 32'd0);
    rd_check("rst_col4", 3'd4, 32'd0);
    rd_check("rst_status", 3'd7, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(3);
    wr(3'd6, 32'd3);
    wr(3'd0, 32'h01); wr(3'd1, 32'h02); wr(3'd2, 32'h04);
    wr(3'd3, 32'h08); wr(3'd4, 32'h10);
    rd_check("dwell_rb", 3'd6, 32'd3);
    rd_check("col3_rb", 3'd3, 32'h08);
    wr(3'd5, 32'd1);
    run(65);

    // back-buffer update lands only at the next frame
    run_until_show(1, 100);
    wr(3'd2, 32'h7f);
    rd_check("col2_rb", 3'd2, 32'h7f);
    run(60);

    wr(3'd5, 32'd3);
    rd_check("ctrl_rb", 3'd5, 32'd3);
    run(40);

    run_until_show(3, 100);
    wr(3'd5, 32'd0);
    run(4);
    rd_check("idle_status", 3'd7, 32'd0);
    wr(3'd5, 32'd1);
    run(40);

    wr(3'd5, 32'd0);
    run(2);
    wr(3'd6, 32'd0);
    wr(3'd5, 32'd1);
    run(40);

    wr(3'd7, 32'hffff_ffff);
    rd_check("status_ro", 3'd6, 32'd0);

    for (int r = 0; r < 6; r++) begin
      wr(3'd5, 32'd0);
      run(2);
      d = 32'($urandom_range(0, 4));
      wr(3'd6, d);
      rd_check("dwell_rand_rb", 3'd6, d);
      wr(3'd5, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
      for (int k = 0; k < 80; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          a = 3'($urandom_range(0, 6));
          if (a == 3'd6) a = 3'd7;
          d = $urandom;
          if (a == 3'd5) d[0] = ($urandom_range(0, 7) != 0);
          wr(a, d);
        end else begin
          run(1);
        end
      end
    end

    wr(3'd5, 32'd0);
    run(2);
    wr(3'd6, 32'd2);
    wr(3'd5, 32'd1);
    run_until_show(2, 200);
    pulse_reset();
    rd_check("post_rst_col0", 3'd0, 32'd0);
    rd_check("post_rst_ctrl", 3'd5, 32'd0);
    run(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_RST, default 16'd49999, giving the reset value of the dwell register (column held DWELL+1 cycles).
REQ-002 SHALL have parameter BLANK_CYC, default 2, giving the number of blanking cycles between columns (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port address, input, 3 bits: Avalon-MM slave register select.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port readdata, output, 32 bits: combinational read data; unused bits 0.
REQ-010 SHALL have port col_out, output, 5 bits: column drive to a 5x7 matrix.
REQ-011 SHALL have port row_out, output, 7 bits: row data, active-high.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at end of each frame.

Function
REQ-013 SHALL accept a write when chipselect=1 and write_n=0, with zero wait states.
REQ-014 SHALL implement this register map:
- 0-4: back buffer column 0-4, bits[6:0], R/W.
- 5: CTRL; bit0 EN, bit1 POL (1 = col_out active-low), R/W.
- 6: DWELL, bits[15:0], R/W.
- 7: STATUS, RO; bits[2:0] current column index, bit3 busy (state != IDLE); writes ignored.
REQ-015 SHALL copy all five back-buffer columns into a shadow buffer on every entry to BLANK with index 0; row_out SHALL be driven only from the shadow buffer.
REQ-016 SHALL implement an FSM with states IDLE, BLANK and SHOW.
REQ-017 IDLE SHALL hold index=0 and move to BLANK (index 0) on the first edge where EN=1.
REQ-018 BLANK SHALL last exactly BLANK_CYC cycles and then move to SHOW.
REQ-019 SHOW SHALL last DWELL+1 cycles, counted by a 16-bit counter from 0 to DWELL. At counter==DWELL the FSM SHALL move to BLANK, and index SHALL advance to index+1, or wrap from 4 to 0.
REQ-020 frame_tick SHALL be 1 in exactly the cycle after the SHOW-to-BLANK transition from index 4.
REQ-021 In SHOW, col_out SHALL equal one-hot(index), bit-inverted when POL=1, and row_out SHALL equal shadow[index].
REQ-022 In IDLE and BLANK, col_out SHALL be inactive (5'b00000, or 5'b11111 when POL=1) and row_out SHALL be 0.
REQ-023 EN=0 observed in any state SHALL force IDLE on the next edge and clear index and both counters.
REQ-024 A DWELL write during SHOW SHALL take effect at the next counter comparison. DWELL=0 SHALL mean 1 cycle per column.
REQ-025 A POL change SHALL affect col_out in the cycle after the write edge.
REQ-026 Frame period SHALL be 5*(DWELL+1+BLANK_CYC) cycles.

Reset
REQ-027 While reset_n=0, all of the following SHALL hold:
- state = IDLE; index = 0; counters = 0.
- back and shadow buffers = 0.
- CTRL = 0; DWELL = DWELL_RST.
- col_out = 5'b00000; row_out = 0; frame_tick = 0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-029 After reset_n is released, the block SHALL stay in IDLE until EN is written to 1.

Verification
REQ-030 Write DWELL=3, then col0..4 = 7'h01, 02, 04, 08, 10, then CTRL=1 -> the first SHOW (col_out=5'b00001, row_out=7'h01) SHALL start 1+BLANK_CYC edges after the FSM observes EN; each column SHALL last 4 cycles; frame_tick SHALL pulse every 30 cycles.
REQ-031 Mid-frame, write col2=7'h7F -> the current frame SHALL still show the old value; the next frame SHALL show 7'h7F at index 2.
REQ-032 Write CTRL=3 (POL=1) while running -> active column bit SHALL be 0 with others 1; during BLANK col_out SHALL be 5'b11111.
REQ-033 Write CTRL=0 during SHOW index 3 -> next cycle IDLE, col_out inactive, STATUS=0; re-enable SHALL restart at index 0.
REQ-034 Pulse reset_n low mid-SHOW -> all outputs SHALL go to reset values asynchronously, and DWELL SHALL read back DWELL_RST.
REQ-035 With DWELL=0 -> 1-cycle columns, index SHALL wrap 4 to 0, and frame_tick SHALL pulse every 5*(1+BLANK_CYC) cycles.
